// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode constants, format codes and the buffered entry type for the
// immediate generator pipeline.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  // Fields are sized for the widest XLEN; narrower builds leave the top bits zero.
  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    logic [MAX_XLEN-1:0] target;
    fmt_e                fmt;
    logic                illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    imm:     64'd0,
    target:  64'd0,
    fmt:     FMT_R,
    illegal: 1'b0
  };

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: maps one instruction and its PC to a
// decoded entry (immediate, PC-relative target, format, illegal flag).
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output entry_t          entry
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] target_x;
  logic            use_target;
  logic            illegal;
  fmt_e            fmt;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];

  // Format decode and immediate assembly; size casts of signed operands sign-extend.
  always_comb begin
    imm_x      = {XLEN{1'b0}};
    fmt        = FMT_NONE;
    illegal    = 1'b0;
    use_target = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm_x = XLEN'($signed(instr[31:20]));
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt = FMT_SH;
          if (IS64) begin
            imm_x = XLEN'(instr[25:20]);
          end else begin
            imm_x = XLEN'(instr[24:20]);
          end
        end else begin
          fmt   = FMT_I;
          imm_x = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_OP_IMM_32: begin
        if (!IS64) begin
          illegal = 1'b1;
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt   = FMT_SH;
          imm_x = XLEN'(instr[24:20]);
        end else begin
          fmt   = FMT_I;
          imm_x = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm_x = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        fmt        = FMT_B;
        imm_x      = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        use_target = 1'b1;
      end
      OPC_LUI: begin
        fmt   = FMT_U;
        imm_x = XLEN'($signed({instr[31:12], 12'h000}));
      end
      OPC_AUIPC: begin
        fmt        = FMT_U;
        imm_x      = XLEN'($signed({instr[31:12], 12'h000}));
        use_target = 1'b1;
      end
      OPC_JAL: begin
        fmt        = FMT_J;
        imm_x      = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        use_target = 1'b1;
      end
      OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm_x = XLEN'(instr[31:20]);
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      OPC_OP_32: begin
        if (IS64) begin
          fmt = FMT_R;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Target is only meaningful for PC-relative formats; wraps modulo 2^XLEN.
  always_comb begin
    if (use_target) begin
      target_x = pc + imm_x;
    end else begin
      target_x = {XLEN{1'b0}};
    end
  end

  assign entry = '{
    imm:     MAX_XLEN'(imm_x),
    target:  MAX_XLEN'(target_x),
    fmt:     fmt,
    illegal: illegal
  };

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one-cycle extraction into a main output
// register backed by a skid register for downstream stalls.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  entry_t new_entry;
  entry_t main_r;
  entry_t skid_r;
  entry_t main_n;
  entry_t skid_n;
  logic   main_valid_r;
  logic   skid_valid_r;
  logic   main_valid_n;
  logic   skid_valid_n;
  logic   in_ready_r;
  logic   accept;
  logic   consume;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (in_instr),
    .pc    (in_pc),
    .entry (new_entry)
  );

  assign accept  = in_valid && in_ready_r;
  assign consume = main_valid_r && out_ready;

  // Next-state for main/skid. in_ready is low whenever skid is full, so an
  // accept never coincides with a skid-to-main move.
  always_comb begin
    main_n       = main_r;
    skid_n       = skid_r;
    main_valid_n = main_valid_r;
    skid_valid_n = skid_valid_r;
    if (!main_valid_r || consume) begin
      if (skid_valid_r) begin
        main_n       = skid_r;
        main_valid_n = 1'b1;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_n       = new_entry;
        main_valid_n = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_n       = new_entry;
      skid_valid_n = 1'b1;
    end else begin
      skid_valid_n = skid_valid_r;
    end
  end

  // Storage update; reset beats flush, flush beats any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_r       <= ENTRY_RESET;
      skid_r       <= ENTRY_RESET;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_r       <= main_n;
      skid_r       <= skid_n;
      main_valid_r <= main_valid_n;
      skid_valid_r <= skid_valid_n;
      in_ready_r   <= !skid_valid_n;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = main_valid_r;
  assign out_imm     = main_r.imm[XLEN-1:0];
  assign out_target  = main_r.target[XLEN-1:0];
  assign out_fmt     = main_r.fmt;
  assign out_illegal = main_r.illegal;

  // Narrow builds never populate the upper entry bits.
  if (XLEN < MAX_XLEN) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_r.imm[MAX_XLEN-1:XLEN], main_r.target[MAX_XLEN-1:XLEN]};
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;

  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target;
  logic [2:0]  out_fmt;

  logic        in_valid64, in_ready64, out_valid64, out_illegal64;
  logic [31:0] in_instr64;
  logic [63:0] in_pc64, out_imm64, out_target64;
  logic [2:0]  out_fmt64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64),
    .out_target(out_target64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
  endtask

  task automatic expect32(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                          input logic [2:0] fmt, input logic ill);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(out_imm), 64'(imm));
    chk({tag, "_tgt"}, 64'(out_target), 64'(tgt));
    chk({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
    chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
  endtask

  task automatic send64(input logic [31:0] instr, input logic [63:0] pc);
    in_valid64 = 1'b1;
    in_instr64 = instr;
    in_pc64    = pc;
    step();
    in_valid64 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFC12083; in_pc = 32'h0;
    in_valid64 = 1'b1; in_instr64 = 32'h800000B7; in_pc64 = 64'd0;
    step();
    step();

    // Reset state, inputs ignored while in reset
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_tgt", 64'(out_target), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst64_out_valid", 64'(out_valid64), 64'd0);

    rst_n = 1'b1;
    in_valid = 1'b0; in_valid64 = 1'b0;
    step();

    // Streaming decode with out_ready held high, one entry per cycle
    send(32'hFFC12083, 32'h0);       expect32("lw",    32'hFFFFFFFC, 32'h0,        3'd1, 1'b0);
    send(32'hFE000CE3, 32'h100);     expect32("beq",   32'hFFFFFFF8, 32'h000000F8, 3'd3, 1'b0);
    send(32'h01F09093, 32'h0);       expect32("slli",  32'h0000001F, 32'h0,        3'd6, 1'b0);
    send(32'h4030D093, 32'h0);       expect32("srai",  32'h00000003, 32'h0,        3'd6, 1'b0);
    send(32'hFE112E23, 32'h0);       expect32("sw",    32'hFFFFFFFC, 32'h0,        3'd2, 1'b0);
    send(32'h0080006F, 32'h200);     expect32("jal",   32'h00000008, 32'h00000208, 3'd5, 1'b0);
    send(32'h12345097, 32'h10);      expect32("auipc", 32'h12345000, 32'h12345010, 3'd4, 1'b0);
    send(32'h123450B7, 32'h10);      expect32("lui",   32'h12345000, 32'h0,        3'd4, 1'b0);
    send(32'hC00020F3, 32'h0);       expect32("csr",   32'h00000C00, 32'h0,        3'd1, 1'b0);
    send(32'h002081B3, 32'h0);       expect32("add",   32'h0,        32'h0,        3'd0, 1'b0);
    send(32'h0000007F, 32'h40);      expect32("bad",   32'h0,        32'h0,        3'd7, 1'b1);
    send(32'h0010009B, 32'h0);       expect32("addiw32", 32'h0,      32'h0,        3'd7, 1'b1);
    send(32'hFFF00093, 32'hFFFFFFF0); expect32("addi_m1", 32'hFFFFFFFF, 32'h0,     3'd1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: entries carry addi immediates 1..4
    out_ready = 1'b0;
    send(32'h00100093, 32'h0);
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    chk("bp_a_imm", 64'(out_imm), 64'd1);
    send(32'h00200093, 32'h0);
    chk("bp_b_ready", 64'(in_ready), 64'd0);
    chk("bp_b_hold_imm", 64'(out_imm), 64'd1);
    send(32'h00300093, 32'h0);
    chk("bp_c_ready", 64'(in_ready), 64'd0);
    chk("bp_c_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_c_hold_imm", 64'(out_imm), 64'd1);
    chk("bp_c_hold_fmt", 64'(out_fmt), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out2_imm", 64'(out_imm), 64'd2);
    chk("bp_out2_ready", 64'(in_ready), 64'd1);
    step();
    chk("bp_out3_imm", 64'(out_imm), 64'd3);
    chk("bp_out3_valid", 64'(out_valid), 64'd1);
    send(32'h00400093, 32'h0);
    chk("bp_out4_imm", 64'(out_imm), 64'd4);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with both registers full and an input offered
    out_ready = 1'b0;
    send(32'h00500093, 32'h0);
    send(32'h00600093, 32'h0);
    in_valid = 1'b1; in_instr = 32'h00700093; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_full_valid", 64'(out_valid), 64'd0);
    chk("fl_full_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("fl_full_after", 64'(out_valid), 64'd0);

    // Flush drops an input that would otherwise have handshaked
    out_ready = 1'b0;
    send(32'h00800093, 32'h0);
    in_valid = 1'b1; in_instr = 32'h00900093; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_drop_valid", 64'(out_valid), 64'd0);
    step();
    chk("fl_drop_after", 64'(out_valid), 64'd0);

    // Reset mid-stream discards the held entry
    out_ready = 1'b0;
    send(32'h00A00093, 32'h0);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_imm", 64'(out_imm), 64'd0);
    out_ready = 1'b1;

    // XLEN=64 instance
    send64(32'h800000B7, 64'd0);
    chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", 64'(out_fmt64), 64'd4);
    send64(32'h0010009B, 64'd0);
    chk("addiw64_imm", out_imm64, 64'd1);
    chk("addiw64_ill", 64'(out_illegal64), 64'd0);
    send64(32'h03F09093, 64'd0);
    chk("slli64_imm", out_imm64, 64'h3F);
    send64(32'hFE000CE3, 64'h0000000100000004);
    chk("beq64_tgt", out_target64, 64'h00000000FFFFFFFC);
    send64(32'h0000007F, 64'd0);
    chk("bad64_ill", 64'(out_illegal64), 64'd1);
    step();
    chk("idle64_valid", 64'(out_valid64), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one 32-bit RISC-V instruction plus its PC per cycle over a valid/ready handshake and returns the sign/zero-extended immediate for every base format (I, S, B, U, J, shift, R). It also returns the PC-relative target for branches, JAL and AUIPC. The block sits between fetch and the register-read/execute stage, and a 2-entry skid buffer absorbs downstream stalls.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discards all buffered entries (pipeline redirect).
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an entry this cycle (registered).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output entry.
- out_imm  out  XLEN  extended immediate.
- out_target  out  XLEN  in_pc+imm for B/J/AUIPC, else 0.
- out_fmt  out  3  format code from imm_pkg.
- out_illegal  out  1  opcode not supported for this XLEN.

## Operation
Decode is keyed on in_instr[6:0]:
- LOAD 0000011, JALR 1100111: I format; imm = sext(instr[31:20]).
- OP-IMM 0010011:
  - funct3 001/101: SH format; imm = zext(shamt), where shamt = instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64. The funct7 bits (e.g. srai 0100000) are never part of imm.
  - Other funct3: I format, sext(instr[31:20]).
- OP-IMM-32 0011011: legal only when XLEN=64. Shifts use a 5-bit shamt (SH format); everything else is I format.
- STORE 0100011: S format; imm = sext({instr[31:25], instr[11:7]}).
- BRANCH 1100011: B format; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- LUI 0110111, AUIPC 0010111: U format; imm = sext({instr[31:12], 12'b0}).
- JAL 1101111: J format; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- SYSTEM 1110011: I format; imm = zext(instr[31:20]) (CSR address).
- OP 0110011, and OP-32 0111011 when XLEN=64: R format; imm = 0.
- Any other opcode, or a 64-bit-only opcode when XLEN=32: fmt NONE, imm = 0, target = 0, out_illegal = 1.
- out_target = in_pc + imm, modulo 2^XLEN, for B, J and AUIPC only.

## Timing
- Latency is 1 cycle. An entry accepted on edge N appears on out_* after edge N.
- Throughput is 1 entry per cycle while out_ready=1.
- Handshake: transfer occurs when valid && ready at an edge. While out_valid=1 && out_ready=0, every out_* signal holds stable.
- Storage is a main register (drives out_*) plus one skid register.
  - Accept while main is empty or being consumed: the entry loads into main.
  - Accept while main is held: the entry goes to skid, and in_ready=0 from the next cycle.
  - Main consumed while skid is full: skid moves to main in the same edge, and in_ready=1 from the next cycle.
  - Ordering is strictly FIFO.
- Simultaneous consume and accept while skid is empty: main reloads with the new entry and out_valid stays 1.
- flush=1 at an edge:
  - Both entries are cleared: out_valid=0 and in_ready=1 next cycle.
  - An input handshaking in the same cycle is dropped.
  - flush overrides accept and consume; rst_n overrides flush.
- Reset (rst_n=0 at an edge): out_valid=0, in_ready=1, out_imm/out_target/out_illegal=0, out_fmt=R. Inputs are ignored during reset. Reset mid-stream discards all entries.

## Structure
- Package imm_pkg holds:
  - opcode localparams (OPC_LOAD … OPC_SYSTEM);
  - fmt codes: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, NONE=7;
  - the entry struct {imm, target, fmt, illegal}.
- Sub-module imm_extract is purely combinational and parametrised by XLEN. It maps instr and pc to an entry.
- imm_gen_pipe contains the main/skid registers and the handshake control.

## Test plan
- XLEN=32, lw x1,-4(x2), instr 0xFFC12083: one cycle later out_imm=0xFFFFFFFC, fmt=I, illegal=0.
- beq x0,x0,-8, instr 0xFE000CE3, pc 0x100: out_imm=0xFFFFFFF8, out_target=0x000000F8, fmt=B.
- Shifts: slli x1,x1,31 (0x01F09093) gives imm=0x1F, fmt=SH; srai x1,x1,3 (0x4030D093) gives imm=0x3, not 0x403.
- Backpressure: 4 back-to-back entries with out_ready=0 for 3 cycles:
  - in_ready drops the cycle after the 2nd accept;
  - out_* stay stable while held;
  - all 4 entries emerge in order with none lost or duplicated.
- flush with main and skid both full and in_valid=1: next cycle out_valid=0, in_ready=1; the concurrent input never appears.
- Illegal and width-dependent cases:
  - instr 0x0000007F gives illegal=1, imm=0, fmt=NONE.
  - XLEN=64, lui 0x800000B7 gives imm=0xFFFFFFFF80000000.
  - XLEN=32, OP-IMM-32 gives illegal=1.
